bullet_controller: RTL and testbench

- Per-player projectile engine feeding the VGA colour mapper's bullet inputs (BulletX/BulletY/bullet_on).
- Launches a bullet from the shooter's ball centre on fire, advances it horizontally once per frame, and retires it on a screen-edge exit or opponent hit.
- Enforces a post-shot cooldown.
- Instantiated twice at top level: player 1 fires right, player 2 fires left.

---
 rtl/game_pkg.sv | 14 +
 rtl/bullet_controller_if.sv | 25 ++
 rtl/frame_tick_gen.sv | 33 +++
 rtl/bullet_controller.sv | 136 +++++++++++++
 tb/tb_bullet_controller.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game constants and the bullet engine state type.
package game_pkg;

    localparam int SCREEN_W            = 640;
    localparam int SCREEN_H            = 480;
    localparam int BULLET_STEP_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } bullet_state_t;

endpackage

// File: rtl/bullet_controller_if.sv
// Per-player bullet bus: shooter/opponent geometry in, bullet position and hit out.
interface bullet_controller_if;

    logic       fire;
    logic [9:0] ShooterX;
    logic [9:0] ShooterY;
    logic [9:0] OppX;
    logic [9:0] OppY;
    logic [9:0] Ball_size;
    logic [9:0] BulletX;
    logic [9:0] BulletY;
    logic       bullet_on;
    logic       hit;

    modport master (
        output fire, ShooterX, ShooterY, OppX, OppY, Ball_size,
        input  BulletX, BulletY, bullet_on, hit
    );

    modport slave (
        input  fire, ShooterX, ShooterY, OppX, OppY, Ball_size,
        output BulletX, BulletY, bullet_on, hit
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous frame clock into Clk and emits a one-cycle tick per rising edge.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = frame_clk;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/bullet_controller.sv
// Single-player projectile engine: launch on fire, advance once per frame tick,
// retire on screen exit or opponent hit, then hold off re-fire for a cooldown.
//
// state    | meaning
// IDLE     | no bullet; launch from shooter centre on a tick with fire held
// FLYING   | bullet visible, advances BULLET_STEP per tick
// COOLDOWN | bullet retired, counting ticks before re-arming
module bullet_controller #(
    parameter int FIRE_RIGHT      = 1,
    parameter int BULLET_STEP     = game_pkg::BULLET_STEP_DEFAULT,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 639
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    bullet_controller_if.slave   bus
);

    import game_pkg::*;

    localparam logic signed [11:0] STEP_S  = 12'(BULLET_STEP);
    localparam logic signed [11:0] XMIN_S  = 12'(X_MIN);
    localparam logic signed [11:0] XMAX_S  = 12'(X_MAX);
    localparam logic        [7:0]  CD_LOAD = 8'(COOLDOWN_FRAMES);

    bullet_state_t state_q, state_d;
    logic [9:0]    bullet_x_q, bullet_x_d;
    logic [9:0]    bullet_y_q, bullet_y_d;
    logic          bullet_on_q, bullet_on_d;
    logic          hit_q, hit_d;
    logic [7:0]    cd_cnt_q, cd_cnt_d;

    logic tick;

    frame_tick_gen u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // Widened signed geometry so box bounds can go negative or past 1023 without wrapping.
    logic signed [11:0] cur_x, cur_y, nx, opp_x, opp_y, half;
    logic               off_screen, in_box;

    always_comb begin
        cur_x = $signed({2'b00, bullet_x_q});
        cur_y = $signed({2'b00, bullet_y_q});
        opp_x = $signed({2'b00, bus.OppX});
        opp_y = $signed({2'b00, bus.OppY});
        half  = $signed({2'b00, bus.Ball_size});
        nx    = (FIRE_RIGHT != 0) ? (cur_x + STEP_S) : (cur_x - STEP_S);
        off_screen = (nx > XMAX_S) || (nx < XMIN_S);
        in_box     = (nx >= (opp_x - half)) && (nx <= (opp_x + half)) &&
                     (cur_y >= (opp_y - half)) && (cur_y <= (opp_y + half));
    end

    always_comb begin
        state_d     = state_q;
        bullet_x_d  = bullet_x_q;
        bullet_y_d  = bullet_y_q;
        bullet_on_d = bullet_on_q;
        hit_d       = 1'b0;
        cd_cnt_d    = cd_cnt_q;

        case (state_q)
            IDLE: begin
                bullet_on_d = 1'b0;
                if (tick && bus.fire) begin
                    bullet_x_d  = bus.ShooterX;
                    bullet_y_d  = bus.ShooterY;
                    bullet_on_d = 1'b1;
                    state_d     = FLYING;
                end
            end
            FLYING: begin
                if (tick) begin
                    if (off_screen) begin
                        bullet_on_d = 1'b0;
                        cd_cnt_d    = CD_LOAD;
                        state_d     = COOLDOWN;
                    end else if (in_box) begin
                        bullet_x_d  = nx[9:0];
                        hit_d       = 1'b1;
                        bullet_on_d = 1'b0;
                        cd_cnt_d    = CD_LOAD;
                        state_d     = COOLDOWN;
                    end else begin
                        bullet_x_d  = nx[9:0];
                    end
                end
            end
            COOLDOWN: begin
                bullet_on_d = 1'b0;
                if (tick) begin
                    if (cd_cnt_q <= 8'd1) begin
                        cd_cnt_d = 8'd0;
                        state_d  = IDLE;
                    end else begin
                        cd_cnt_d = cd_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                bullet_on_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            bullet_x_q  <= 10'd0;
            bullet_y_q  <= 10'd0;
            bullet_on_q <= 1'b0;
            hit_q       <= 1'b0;
            cd_cnt_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            bullet_x_q  <= bullet_x_d;
            bullet_y_q  <= bullet_y_d;
            bullet_on_q <= bullet_on_d;
            hit_q       <= hit_d;
            cd_cnt_q    <= cd_cnt_d;
        end
    end

    assign bus.BulletX   = bullet_x_q;
    assign bus.BulletY   = bullet_y_q;
    assign bus.bullet_on = bullet_on_q;
    assign bus.hit       = hit_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for a right-firing and a left-firing bullet_controller sharing one frame clock.
module tb_bullet_controller;

    logic Clk = 1'b0;
    logic Reset;
    logic frame_clk;

    always #10 Clk = ~Clk;

    bullet_controller_if bus_r();
    bullet_controller_if bus_l();

    bullet_controller #(
        .FIRE_RIGHT(1), .BULLET_STEP(4), .COOLDOWN_FRAMES(30), .X_MIN(0), .X_MAX(639)
    ) dut_r (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .bus(bus_r.slave)
    );

    bullet_controller #(
        .FIRE_RIGHT(0), .BULLET_STEP(4), .COOLDOWN_FRAMES(30), .X_MIN(0), .X_MAX(639)
    ) dut_l (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .bus(bus_l.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int hits_r = 0;
    int hits_l = 0;

    // Counts Clk cycles on which each hit output is high.
    always @(negedge Clk) begin
        if (bus_r.hit === 1'b1) hits_r++;
        if (bus_l.hit === 1'b1) hits_l++;
    end

    task automatic frame_tick();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic apply_reset();
        @(negedge Clk) Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++; if (bus_r.BulletX !== 10'd0) begin n_bad++; $display("FAIL reset_x: got %0d expected 0", bus_r.BulletX); end
        n_cmp++; if (bus_r.BulletY !== 10'd0) begin n_bad++; $display("FAIL reset_y: got %0d expected 0", bus_r.BulletY); end
        n_cmp++; if (bus_r.bullet_on !== 1'b0) begin n_bad++; $display("FAIL reset_on: got %b expected 0", bus_r.bullet_on); end
        n_cmp++; if (bus_r.hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit: got %b expected 0", bus_r.hit); end
        n_cmp++; if (bus_l.bullet_on !== 1'b0) begin n_bad++; $display("FAIL reset_on_l: got %b expected 0", bus_l.bullet_on); end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_launch_fly();
        apply_reset();
        bus_r.ShooterX = 10'd100; bus_r.ShooterY = 10'd200; bus_r.fire = 1'b1;
        frame_tick();
        bus_r.fire = 1'b0;
        n_cmp++; if (bus_r.BulletX !== 10'd100) begin n_bad++; $display("FAIL launch_x: got %0d expected 100", bus_r.BulletX); end
        n_cmp++; if (bus_r.BulletY !== 10'd200) begin n_bad++; $display("FAIL launch_y: got %0d expected 200", bus_r.BulletY); end
        n_cmp++; if (bus_r.bullet_on !== 1'b1) begin n_bad++; $display("FAIL launch_on: got %b expected 1", bus_r.bullet_on); end
        bus_r.ShooterY = 10'd50;
        for (int i = 1; i <= 5; i++) begin
            frame_tick();
            n_cmp++;
            if (bus_r.BulletX !== 10'(100 + 4 * i)) begin
                n_bad++; $display("FAIL fly_x step %0d: got %0d expected %0d", i, bus_r.BulletX, 100 + 4 * i);
            end
        end
        n_cmp++; if (bus_r.BulletY !== 10'd200) begin n_bad++; $display("FAIL fly_y_frozen: got %0d expected 200", bus_r.BulletY); end
        n_cmp++; if (bus_r.bullet_on !== 1'b1) begin n_bad++; $display("FAIL fly_on: got %b expected 1", bus_r.bullet_on); end
    endtask

    task automatic test_reset_mid_flight();
        apply_reset();
        bus_r.ShooterX = 10'd300; bus_r.ShooterY = 10'd200; bus_r.fire = 1'b1;
        frame_tick();
        bus_r.fire = 1'b0;
        n_cmp++; if (bus_r.BulletX !== 10'd300) begin n_bad++; $display("FAIL midrst_launch_x: got %0d expected 300", bus_r.BulletX); end
        apply_reset();
        n_cmp++; if (bus_r.bullet_on !== 1'b0) begin n_bad++; $display("FAIL midrst_on: got %b expected 0", bus_r.bullet_on); end
        n_cmp++; if (bus_r.BulletX !== 10'd0) begin n_bad++; $display("FAIL midrst_x: got %0d expected 0", bus_r.BulletX); end
        n_cmp++; if (bus_r.BulletY !== 10'd0) begin n_bad++; $display("FAIL midrst_y: got %0d expected 0", bus_r.BulletY); end
        n_cmp++; if (bus_r.hit !== 1'b0) begin n_bad++; $display("FAIL midrst_hit: got %b expected 0", bus_r.hit); end
        bus_r.ShooterX = 10'd50; bus_r.ShooterY = 10'd60; bus_r.fire = 1'b1;
        frame_tick();
        bus_r.fire = 1'b0;
        n_cmp++; if (bus_r.BulletX !== 10'd50 || bus_r.bullet_on !== 1'b1) begin
            n_bad++; $display("FAIL midrst_relaunch: got x=%0d on=%b expected x=50 on=1", bus_r.BulletX, bus_r.bullet_on);
        end
    endtask

    task automatic test_fire_between_ticks();
        apply_reset();
        bus_r.ShooterX = 10'd100; bus_r.ShooterY = 10'd200;
        @(negedge Clk) bus_r.fire = 1'b1;
        repeat (3) @(negedge Clk);
        bus_r.fire = 1'b0;
        frame_tick();
        n_cmp++; if (bus_r.bullet_on !== 1'b0) begin n_bad++; $display("FAIL fire_between: got %b expected 0", bus_r.bullet_on); end
    endtask

    task automatic test_edge_cooldown();
        int h0;
        int seen_on;
        apply_reset();
        bus_r.OppX = 10'd0; bus_r.OppY = 10'd0; bus_r.Ball_size = 10'd4;
        bus_r.ShooterX = 10'd636; bus_r.ShooterY = 10'd200; bus_r.fire = 1'b1;
        h0 = hits_r;
        frame_tick();
        n_cmp++; if (bus_r.BulletX !== 10'd636 || bus_r.bullet_on !== 1'b1) begin
            n_bad++; $display("FAIL edge_launch: got x=%0d on=%b expected x=636 on=1", bus_r.BulletX, bus_r.bullet_on);
        end
        bus_r.ShooterX = 10'd500;
        frame_tick();
        n_cmp++; if (bus_r.bullet_on !== 1'b0) begin n_bad++; $display("FAIL edge_exit_on: got %b expected 0", bus_r.bullet_on); end
        n_cmp++; if (bus_r.BulletX !== 10'd636) begin n_bad++; $display("FAIL edge_exit_x: got %0d expected 636", bus_r.BulletX); end
        seen_on = 0;
        for (int i = 1; i <= 30; i++) begin
            frame_tick();
            if (bus_r.bullet_on !== 1'b0) seen_on++;
        end
        n_cmp++; if (seen_on != 0) begin n_bad++; $display("FAIL cooldown_quiet: got %0d ticks with bullet_on expected 0", seen_on); end
        frame_tick();
        n_cmp++; if (bus_r.bullet_on !== 1'b1 || bus_r.BulletX !== 10'd500) begin
            n_bad++; $display("FAIL autorepeat_tick31: got x=%0d on=%b expected x=500 on=1", bus_r.BulletX, bus_r.bullet_on);
        end
        n_cmp++; if (hits_r != h0) begin n_bad++; $display("FAIL edge_no_hit: got %0d hit cycles expected 0", hits_r - h0); end
        bus_r.fire = 1'b0;
    endtask

    task automatic test_hit();
        int h0;
        apply_reset();
        bus_r.OppX = 10'd400; bus_r.OppY = 10'd200; bus_r.Ball_size = 10'd4;
        bus_r.ShooterX = 10'd392; bus_r.ShooterY = 10'd200; bus_r.fire = 1'b1;
        frame_tick();
        bus_r.fire = 1'b0;
        n_cmp++; if (bus_r.BulletX !== 10'd392 || bus_r.bullet_on !== 1'b1) begin
            n_bad++; $display("FAIL hit_launch: got x=%0d on=%b expected x=392 on=1", bus_r.BulletX, bus_r.bullet_on);
        end
        h0 = hits_r;
        frame_tick();
        n_cmp++; if (bus_r.BulletX !== 10'd396) begin n_bad++; $display("FAIL hit_x: got %0d expected 396", bus_r.BulletX); end
        n_cmp++; if (bus_r.bullet_on !== 1'b0) begin n_bad++; $display("FAIL hit_on: got %b expected 0", bus_r.bullet_on); end
        n_cmp++; if (hits_r - h0 != 1) begin n_bad++; $display("FAIL hit_pulse_len: got %0d cycles expected 1", hits_r - h0); end
        repeat (3) frame_tick();
        n_cmp++; if (hits_r - h0 != 1 || bus_r.bullet_on !== 1'b0) begin
            n_bad++; $display("FAIL hit_cooldown_quiet: got hits=%0d on=%b expected hits=1 on=0", hits_r - h0, bus_r.bullet_on);
        end
    endtask

    task automatic test_miss_y();
        int h0;
        int n;
        apply_reset();
        bus_r.OppX = 10'd400; bus_r.OppY = 10'd200; bus_r.Ball_size = 10'd4;
        bus_r.ShooterX = 10'd392; bus_r.ShooterY = 10'd210; bus_r.fire = 1'b1;
        frame_tick();
        bus_r.fire = 1'b0;
        h0 = hits_r;
        n = 0;
        while (bus_r.bullet_on === 1'b1 && n < 100) begin
            frame_tick();
            n++;
        end
        n_cmp++; if (n != 62) begin n_bad++; $display("FAIL miss_flight_ticks: got %0d expected 62", n); end
        n_cmp++; if (bus_r.BulletX !== 10'd636) begin n_bad++; $display("FAIL miss_last_x: got %0d expected 636", bus_r.BulletX); end
        n_cmp++; if (hits_r != h0) begin n_bad++; $display("FAIL miss_no_hit: got %0d hit cycles expected 0", hits_r - h0); end
    endtask

    task automatic test_offscreen_priority();
        int h0;
        apply_reset();
        bus_r.OppX = 10'd639; bus_r.OppY = 10'd200; bus_r.Ball_size = 10'd4;
        bus_r.ShooterX = 10'd636; bus_r.ShooterY = 10'd200; bus_r.fire = 1'b1;
        frame_tick();
        bus_r.fire = 1'b0;
        h0 = hits_r;
        frame_tick();
        n_cmp++; if (bus_r.bullet_on !== 1'b0 || bus_r.BulletX !== 10'd636) begin
            n_bad++; $display("FAIL prio_exit: got x=%0d on=%b expected x=636 on=0", bus_r.BulletX, bus_r.bullet_on);
        end
        n_cmp++; if (hits_r != h0) begin n_bad++; $display("FAIL prio_no_hit: got %0d hit cycles expected 0", hits_r - h0); end
    endtask

    task automatic test_left_neg_bound();
        int h0;
        apply_reset();
        bus_l.OppX = 10'd2; bus_l.OppY = 10'd200; bus_l.Ball_size = 10'd10;
        bus_l.ShooterX = 10'd30; bus_l.ShooterY = 10'd200; bus_l.fire = 1'b1;
        frame_tick();
        bus_l.fire = 1'b0;
        n_cmp++; if (bus_l.BulletX !== 10'd30 || bus_l.bullet_on !== 1'b1) begin
            n_bad++; $display("FAIL left_launch: got x=%0d on=%b expected x=30 on=1", bus_l.BulletX, bus_l.bullet_on);
        end
        h0 = hits_l;
        repeat (4) frame_tick();
        n_cmp++; if (bus_l.BulletX !== 10'd14 || bus_l.bullet_on !== 1'b1 || hits_l != h0) begin
            n_bad++; $display("FAIL left_approach: got x=%0d on=%b hits=%0d expected x=14 on=1 hits=0", bus_l.BulletX, bus_l.bullet_on, hits_l - h0);
        end
        frame_tick();
        n_cmp++; if (bus_l.BulletX !== 10'd10 || bus_l.bullet_on !== 1'b0) begin
            n_bad++; $display("FAIL negbound_hit_pos: got x=%0d on=%b expected x=10 on=0", bus_l.BulletX, bus_l.bullet_on);
        end
        n_cmp++; if (hits_l - h0 != 1) begin n_bad++; $display("FAIL negbound_hit_pulse: got %0d cycles expected 1", hits_l - h0); end
    endtask

    task automatic test_left_wrap();
        int h0;
        apply_reset();
        bus_l.OppX = 10'd600; bus_l.OppY = 10'd0; bus_l.Ball_size = 10'd4;
        bus_l.ShooterX = 10'd2; bus_l.ShooterY = 10'd100; bus_l.fire = 1'b1;
        frame_tick();
        bus_l.fire = 1'b0;
        n_cmp++; if (bus_l.BulletX !== 10'd2 || bus_l.bullet_on !== 1'b1) begin
            n_bad++; $display("FAIL wrap_launch: got x=%0d on=%b expected x=2 on=1", bus_l.BulletX, bus_l.bullet_on);
        end
        h0 = hits_l;
        frame_tick();
        n_cmp++; if (bus_l.bullet_on !== 1'b0 || bus_l.BulletX !== 10'd2) begin
            n_bad++; $display("FAIL wrap_retire: got x=%0d on=%b expected x=2 on=0", bus_l.BulletX, bus_l.bullet_on);
        end
        n_cmp++; if (hits_l != h0) begin n_bad++; $display("FAIL wrap_no_hit: got %0d hit cycles expected 0", hits_l - h0); end
    endtask

    initial begin
        Reset = 1'b1;
        frame_clk = 1'b0;
        bus_r.fire = 1'b0; bus_r.ShooterX = 10'd0; bus_r.ShooterY = 10'd0;
        bus_r.OppX = 10'd0; bus_r.OppY = 10'd0; bus_r.Ball_size = 10'd4;
        bus_l.fire = 1'b0; bus_l.ShooterX = 10'd0; bus_l.ShooterY = 10'd0;
        bus_l.OppX = 10'd600; bus_l.OppY = 10'd0; bus_l.Ball_size = 10'd4;

        test_reset();
        test_launch_fly();
        test_reset_mid_flight();
        test_fire_between_ticks();
        test_edge_cooldown();
        test_hit();
        test_miss_y();
        test_offscreen_priority();
        test_left_neg_bound();
        test_left_wrap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
